// File: rtl/elastic_pipeline_stage.sv
// In-order elastic buffer of DEPTH address/ID entries: adds stage_offset on entry, flushes by ID or all, forwards flush one cycle later.
// Latency 1 cycle when empty; out_stall is registered-state only (full), no combinational path from in_stall.
module elastic_pipeline_stage #(
    parameter int ADDR_W = 16,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] stage_offset,
    input  logic [ADDR_W-1:0] in_address,
    input  logic [ID_W-1:0]   in_id,
    input  logic              in_valid,
    output logic              out_stall,
    input  logic              in_flush,
    input  logic [ID_W-1:0]   in_flush_id,
    input  logic              in_flush_all,
    output logic [ADDR_W-1:0] out_address,
    output logic [ID_W-1:0]   out_id,
    output logic              out_valid,
    input  logic              in_stall,
    output logic              out_flush,
    output logic [ID_W-1:0]   out_flush_id,
    output logic              out_flush_all,
    output logic [CNT_W-1:0]  occupancy
);

    generate
        if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
            $error("elastic_pipeline_stage: DEPTH must be in the range 2..16");
        end
    endgenerate

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [ID_W-1:0]   id_q   [DEPTH];
    logic [ID_W-1:0]   id_d   [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              flush_q;
    logic [ID_W-1:0]   flush_id_q;
    logic              flush_all_q;

    // Intermediate view after pop and push, before flush/compaction
    logic [ADDR_W-1:0] stg_addr [DEPTH];
    logic [ID_W-1:0]   stg_id   [DEPTH];
    logic [CNT_W-1:0]  stg_cnt;
    logic [CNT_W-1:0]  stg_cnt_push;
    logic [CNT_W-1:0]  keep_cnt;
    logic [ADDR_W-1:0] push_addr;
    logic              push;
    logic              pop;
    logic              hit;

    assign out_valid     = (cnt_q != '0);
    assign out_stall     = (cnt_q == FULL_CNT);
    assign out_address   = addr_q[0];
    assign out_id        = id_q[0];
    assign occupancy     = cnt_q;
    assign out_flush     = flush_q;
    assign out_flush_id  = flush_id_q;
    assign out_flush_all = flush_all_q;

    always_comb begin
        push      = in_valid && !out_stall;
        pop       = out_valid && !in_stall;
        push_addr = in_address + stage_offset;
        hit       = 1'b0;

        for (int i = 0; i < DEPTH - 1; i++) begin
            stg_addr[i] = pop ? addr_q[i+1] : addr_q[i];
            stg_id[i]   = pop ? id_q[i+1]   : id_q[i];
        end
        stg_addr[DEPTH-1] = pop ? '0 : addr_q[DEPTH-1];
        stg_id[DEPTH-1]   = pop ? '0 : id_q[DEPTH-1];
        stg_cnt           = cnt_q - CNT_W'(pop);

        for (int i = 0; i < DEPTH; i++) begin
            if (push && (CNT_W'(i) == stg_cnt)) begin
                stg_addr[i] = push_addr;
                stg_id[i]   = in_id;
            end
        end
        stg_cnt_push = stg_cnt + CNT_W'(push);

        // Survivors are packed toward the head; unused slots stay zero so an empty head reads 0
        for (int i = 0; i < DEPTH; i++) begin
            addr_d[i] = '0;
            id_d[i]   = '0;
        end
        keep_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit = in_flush && (in_flush_all || (stg_id[i] == in_flush_id));
            if ((CNT_W'(i) < stg_cnt_push) && !hit) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (CNT_W'(j) == keep_cnt) begin
                        addr_d[j] = stg_addr[i];
                        id_d[j]   = stg_id[i];
                    end
                end
                keep_cnt = keep_cnt + CNT_W'(1);
            end
        end
        cnt_d = keep_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                id_q[i]   <= '0;
            end
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            flush_id_q  <= '0;
            flush_all_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                id_q[i]   <= id_d[i];
            end
            cnt_q       <= cnt_d;
            flush_q     <= in_flush;
            flush_id_q  <= in_flush_id;
            flush_all_q <= in_flush_all;
        end
    end

endmodule
